vco_band_cal: RTL
=================

// Module: vco_band_cal
// PURPOSE
//  Digital coarse-band calibration for the tunable VCO. Counts edges of the divided VCO output
//  over a fixed refclk window, then binary-searches (SAR) the 5-bit tune code so the VCO
//  frequency lands on a target count. Holds VCO control at mid-rail during calibration.
//  Sits between the VCO model (drives its tune, vctrl_hold) and the PLL loop enable.
// PARAMETERS
//  TUNE_W      5        width of tune code
//  CNT_W       12       width of edge counter / target
//  WIN_CYC     1024     measurement window length, refclk cycles
//  SETTLE_CYC  64       wait after each tune change before measuring, refclk cycles
//  TUNE_RST    5'b01111 tune value in reset and idle-after-reset
// PORTS
//  refclk      in   1       clock, all state on rising edge
//  rst_n       in   1       async active-low reset
//  start       in   1       one-cycle request to start calibration
//  target_cnt  in   CNT_W   desired edge count per window; sampled when start is accepted
//  vco_div     in   1       divided VCO clock, asynchronous to refclk, f < refclk/4
//  tune        out  TUNE_W  band-select code to VCO
//  vctrl_hold  out  1       1 = force VCO control to mid-rail (high while busy)
//  busy        out  1       calibration in progress
//  done        out  1       sticky: calibration complete; cleared when next start is accepted
//  cal_err     out  1       target outside reachable range (valid with done)
//  meas_cnt    out  CNT_W   edge count of the most recent window
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, tune=TUNE_RST, busy=0, vctrl_hold=0, done=0,
//   cal_err=0, meas_cnt=0, counters 0, synchronizer flops 0. Reset mid-operation aborts
//   immediately; no partial result is kept.
//  vco_div passes a 2-flop synchronizer + rising-edge detect (1 pulse per edge, 3-cycle lag).
//  FSM states: IDLE, SETTLE, MEASURE, DECIDE, DONE.
//   IDLE: start=1 -> latch target, tune=1<<(TUNE_W-1), bit=TUNE_W-1, done=0, cal_err=0,
//     busy=vctrl_hold=1 next cycle, go SETTLE. start while not IDLE/DONE is ignored.
//   SETTLE: count SETTLE_CYC cycles, then MEASURE with edge counter cleared.
//   MEASURE: exactly WIN_CYC cycles; each edge pulse in the window increments counter,
//     saturating at 2^CNT_W-1. On leaving, meas_cnt <= counter.
//   DECIDE (1 cycle): meas_cnt >= target -> clear tune[bit], else keep it.
//     bit>0: set tune[bit-1], bit--, go SETTLE. bit==0: go DONE.
//   DONE: busy=0, vctrl_hold=0, done=1; start=1 restarts as from IDLE.
//  Per step: SETTLE_CYC+WIN_CYC+1 cycles; done rises TUNE_W*(SETTLE_CYC+WIN_CYC+1)+1
//   cycles after the cycle start is sampled.
//  cal_err=1 at DONE iff (tune all ones and last meas_cnt < target) or
//   (tune all zeros and last meas_cnt > target).
//  Ties (meas_cnt == target) clear the bit; higher tune = higher frequency.
//  tune only changes in the start-accept cycle and in DECIDE; never glitches mid-window.
// STRUCTURE
//  Package vco_cal_pkg: typedef enum logic[2:0] cal_state_t {IDLE,SETTLE,MEASURE,DECIDE,DONE};
//   default localparams TUNE_W, CNT_W; shared with the VCO model bench.
//  Sub-module sync_edge_det: 2-FF synchronizer + rising-edge pulse (refclk, rst_n, d, pulse).
//  Top holds FSM, SAR register, bit index, window/settle counter, saturating edge counter.
// TESTING (sim params WIN_CYC=64, SETTLE_CYC=8; VCO model: edges/window = 4*tune)
//  Reset asserted at time 0 and mid-MEASURE -> tune=01111, busy=done=cal_err=0, meas_cnt=0.
//  target=60 -> steps 10000(64) clr, 01000(32), 01100(48), 01110(56) keep, 01111(60) clr;
//   final tune=01110, cal_err=0, done 366 cycles after start.
//  target=200 -> tune=11111, cal_err=1; target=0 -> tune=00000, cal_err=1.
//  start pulsed during SETTLE/MEASURE -> ignored, result and timing identical to single start.
//  start in DONE -> done drops next cycle, new calibration runs with newly latched target.
//  vco_div at refclk/4 with CNT_W=4 -> meas_cnt saturates at 15, no wrap.

Source files
------------

// File: rtl/vco_cal_pkg.sv
// Shared types and default widths for the VCO coarse-band calibration block
// and the VCO model used alongside it.
package vco_cal_pkg;

  localparam int TUNE_W = 5;
  localparam int CNT_W  = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    MEASURE = 3'd2,
    DECIDE  = 3'd3,
    DONE    = 3'd4
  } cal_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for the asynchronous divided VCO clock followed by a
// rising-edge detector; one refclk-wide pulse per vco_div rising edge.
module sync_edge_det (
  input  logic refclk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic meta_r;
  logic sync_r;
  logic hist_r;

  // meta_r may go metastable; only sync_r and hist_r feed logic
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      hist_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
      hist_r <= sync_r;
    end
  end

  assign pulse = sync_r & ~hist_r;

endmodule

// File: rtl/vco_band_cal.sv
// VCO coarse-band calibration: counts divided-VCO edges over a refclk window
// and successively approximates the tune code toward the target count.
module vco_band_cal #(
  parameter int                TUNE_W     = vco_cal_pkg::TUNE_W,
  parameter int                CNT_W      = vco_cal_pkg::CNT_W,
  parameter int                WIN_CYC    = 1024,
  parameter int                SETTLE_CYC = 64,
  parameter logic [TUNE_W-1:0] TUNE_RST   = {1'b0, {(TUNE_W-1){1'b1}}}
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  target_cnt,
  input  logic              vco_div,
  output logic [TUNE_W-1:0] tune,
  output logic              vctrl_hold,
  output logic              busy,
  output logic              done,
  output logic              cal_err,
  output logic [CNT_W-1:0]  meas_cnt
);

  import vco_cal_pkg::*;

  localparam int                TIM_W       = $clog2(WIN_CYC + SETTLE_CYC + 1);
  localparam int                BIT_W       = (TUNE_W > 1) ? $clog2(TUNE_W) : 1;
  localparam logic [TIM_W-1:0]  SETTLE_LAST = TIM_W'(SETTLE_CYC - 1);
  localparam logic [TIM_W-1:0]  WIN_LAST    = TIM_W'(WIN_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [TUNE_W-1:0] TUNE_MID    = {1'b1, {(TUNE_W-1){1'b0}}};
  localparam logic [BIT_W-1:0]  BIT_TOP     = BIT_W'(TUNE_W - 1);

  cal_state_t        state_r;
  logic [BIT_W-1:0]  bit_idx_r;
  logic [TIM_W-1:0]  tim_r;
  logic [CNT_W-1:0]  edge_cnt_r;
  logic [CNT_W-1:0]  target_r;
  logic              edge_pulse_s;
  logic [CNT_W-1:0]  edge_inc_s;
  logic [TUNE_W-1:0] tune_dec_s;
  logic              clear_s;
  logic              err_s;

  sync_edge_det u_sync (
    .refclk (refclk),
    .rst_n  (rst_n),
    .d      (vco_div),
    .pulse  (edge_pulse_s)
  );

  // Saturating edge count including a pulse landing in the current cycle
  always_comb begin
    if (edge_pulse_s && (edge_cnt_r != CNT_MAX)) begin
      edge_inc_s = edge_cnt_r + CNT_W'(1);
    end else begin
      edge_inc_s = edge_cnt_r;
    end
  end

  // SAR step: ties clear the trial bit; the next lower bit becomes the new trial
  always_comb begin
    clear_s = (meas_cnt >= target_r);
    for (int i = 0; i < TUNE_W; i++) begin
      if (i == int'(bit_idx_r)) begin
        tune_dec_s[i] = tune[i] & ~clear_s;
      end else if ((i + 1) == int'(bit_idx_r)) begin
        tune_dec_s[i] = 1'b1;
      end else begin
        tune_dec_s[i] = tune[i];
      end
    end
    err_s = ((&tune) && (meas_cnt < target_r)) || ((~|tune) && (meas_cnt > target_r));
  end

  // Calibration sequencer, SAR register and window/settle timing
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      tune       <= TUNE_RST;
      bit_idx_r  <= '0;
      tim_r      <= '0;
      edge_cnt_r <= '0;
      target_r   <= '0;
      meas_cnt   <= '0;
      busy       <= 1'b0;
      vctrl_hold <= 1'b0;
      done       <= 1'b0;
      cal_err    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            target_r   <= target_cnt;
            tune       <= TUNE_MID;
            bit_idx_r  <= BIT_TOP;
            tim_r      <= '0;
            done       <= 1'b0;
            cal_err    <= 1'b0;
            busy       <= 1'b1;
            vctrl_hold <= 1'b1;
            state_r    <= SETTLE;
          end else if (state_r == DONE) begin
            busy       <= 1'b0;
            vctrl_hold <= 1'b0;
            done       <= 1'b1;
            cal_err    <= err_s;
          end else begin
            busy       <= 1'b0;
            vctrl_hold <= 1'b0;
          end
        end
        SETTLE: begin
          if (tim_r == SETTLE_LAST) begin
            tim_r      <= '0;
            edge_cnt_r <= '0;
            state_r    <= MEASURE;
          end else begin
            tim_r <= tim_r + TIM_W'(1);
          end
        end
        MEASURE: begin
          edge_cnt_r <= edge_inc_s;
          if (tim_r == WIN_LAST) begin
            tim_r    <= '0;
            meas_cnt <= edge_inc_s;
            state_r  <= DECIDE;
          end else begin
            tim_r <= tim_r + TIM_W'(1);
          end
        end
        DECIDE: begin
          tune <= tune_dec_s;
          if (bit_idx_r != '0) begin
            bit_idx_r <= bit_idx_r - BIT_W'(1);
            state_r   <= SETTLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
